// File: rtl/axis_to_fifo_writer.sv
// AXI-Stream sink that writes beats (data, last, keep) into a synchronous FIFO write port.
// A two-entry skid buffer keeps tready_out registered; over-long frames are truncated.
module axis_to_fifo_writer #(
    parameter int DATA_SIZE       = 512,
    parameter int MAX_FRAME_BEATS = 64,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tvalid_in,
    output logic                   tready_out,
    input  logic [DATA_SIZE-1:0]   tdata_in,
    input  logic                   tlast_in,
    input  logic [DATA_SIZE/8-1:0] tkeep_in,
    output logic                   fifo_write_enable,
    output logic [DATA_SIZE-1:0]   fifo_data_in,
    output logic                   fifo_last_in,
    output logic [DATA_SIZE/8-1:0] fifo_keep_in,
    input  logic                   fifo_full,
    output logic                   frame_done,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic [COUNT_WIDTH-1:0] truncated_count
);

    localparam int          KEEP_SIZE = DATA_SIZE / 8;
    localparam logic [15:0] MAX_BEATS = 16'(MAX_FRAME_BEATS);

    typedef enum logic [1:0] {
        IDLE,
        IN_FRAME,
        DISCARD
    } state_t;

    state_t state, state_next;
    logic [15:0] beat_cnt, beat_cnt_next;
    logic accept, store, force_last, tready_next;

    // Output register (OR) drives the FIFO port; skid register (SK) absorbs one beat of stall.
    logic                 or_valid, or_valid_next, or_last, or_last_next;
    logic [DATA_SIZE-1:0] or_data, or_data_next;
    logic [KEEP_SIZE-1:0] or_keep, or_keep_next;
    logic                 sk_valid, sk_valid_next, sk_last, sk_last_next;
    logic [DATA_SIZE-1:0] sk_data, sk_data_next;
    logic [KEEP_SIZE-1:0] sk_keep, sk_keep_next;

    assign accept            = tvalid_in & tready_out;
    assign fifo_write_enable = or_valid & ~fifo_full;
    assign fifo_data_in      = or_data;
    assign fifo_last_in      = or_last;
    assign fifo_keep_in      = or_keep;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        store         = 1'b0;
        force_last    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    store         = 1'b1;
                    beat_cnt_next = 16'd1;
                    if (!tlast_in) state_next = IN_FRAME;
                end
            end
            IN_FRAME: begin
                if (accept) begin
                    store         = 1'b1;
                    beat_cnt_next = beat_cnt + 16'd1;
                    if (tlast_in) begin
                        state_next = IDLE;
                    end else if (beat_cnt_next == MAX_BEATS) begin
                        force_last = 1'b1;
                        state_next = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (accept && tlast_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        or_valid_next = or_valid;
        or_last_next  = or_last;
        or_data_next  = or_data;
        or_keep_next  = or_keep;
        sk_valid_next = sk_valid;
        sk_last_next  = sk_last;
        sk_data_next  = sk_data;
        sk_keep_next  = sk_keep;
        if (fifo_write_enable && sk_valid) begin
            or_valid_next = 1'b1;
            or_last_next  = sk_last;
            or_data_next  = sk_data;
            or_keep_next  = sk_keep;
            sk_valid_next = store;
            if (store) begin
                sk_last_next = tlast_in | force_last;
                sk_data_next = tdata_in;
                sk_keep_next = tkeep_in;
            end
        end else if (fifo_write_enable || !or_valid) begin
            or_valid_next = store;
            if (store) begin
                or_last_next = tlast_in | force_last;
                or_data_next = tdata_in;
                or_keep_next = tkeep_in;
            end
        end else if (store) begin
            sk_valid_next = 1'b1;
            sk_last_next  = tlast_in | force_last;
            sk_data_next  = tdata_in;
            sk_keep_next  = tkeep_in;
        end
    end

    // Dropped beats never touch the buffer, so DISCARD can keep accepting unconditionally.
    assign tready_next = (state_next == DISCARD) | ~sk_valid_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            beat_cnt        <= '0;
            tready_out      <= 1'b0;
            or_valid        <= 1'b0;
            or_last         <= 1'b0;
            or_data         <= '0;
            or_keep         <= '0;
            sk_valid        <= 1'b0;
            sk_last         <= 1'b0;
            sk_data         <= '0;
            sk_keep         <= '0;
            frame_done      <= 1'b0;
            frame_count     <= '0;
            truncated_count <= '0;
        end else begin
            state      <= state_next;
            beat_cnt   <= beat_cnt_next;
            tready_out <= tready_next;
            or_valid   <= or_valid_next;
            or_last    <= or_last_next;
            or_data    <= or_data_next;
            or_keep    <= or_keep_next;
            sk_valid   <= sk_valid_next;
            sk_last    <= sk_last_next;
            sk_data    <= sk_data_next;
            sk_keep    <= sk_keep_next;
            frame_done <= fifo_write_enable & or_last;
            if (fifo_write_enable && or_last) frame_count <= frame_count + 1'b1;
            if (store && force_last) truncated_count <= truncated_count + 1'b1;
        end
    end

endmodule
